acc_ctrl: RTL

- Multi-cycle command sequencer directly upstream of the 4-bit register and ALU.
- Accepts one command per valid/ready handshake and drives the register's control strobes and data input.
- Drives the ALU opcode and operand b; ALU operand a is the register output, wired outside this block.
- Guarantees at most one register strobe per cycle, so behaviour never depends on the register's internal priority.

---
 rtl/acc_ctrl_pkg.sv | 21 ++
 rtl/acc_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/acc_ctrl_pkg.sv
// acc_ctrl shared constants: command op codes,
// sequencer state encoding, shift-control bits.
package acc_ctrl_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_CLR  = 3'd1;
  localparam logic [2:0] OP_LOAD = 3'd2;
  localparam logic [2:0] OP_ALU  = 3'd3;
  localparam logic [2:0] OP_INC  = 3'd4;
  localparam logic [2:0] OP_DEC  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_SHL  = 3'd7;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;

  localparam int SC_ROT = 1;
  localparam int SC_SER = 0;

endpackage

// File: rtl/acc_ctrl.sv
// acc_ctrl: command sequencer for a W-bit register + ALU.
// Ports: clk, rst_n (sync, low); cmd_valid/ready/op/oc/data/cnt;
// reg_out, alu_f in; alu_oc, alu_b, cl, ld, inc, dec, sr, sl,
// ir, il, reg_in, busy, done out.
module acc_ctrl
  import acc_ctrl_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [2:0]       cmd_oc,
  input  logic [W-1:0]     cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [W-1:0]     reg_out,
  input  logic [W-1:0]     alu_f,
  output logic [2:0]       alu_oc,
  output logic [W-1:0]     alu_b,
  output logic             cl,
  output logic             ld,
  output logic             inc,
  output logic             dec,
  output logic             sr,
  output logic             sl,
  output logic             ir,
  output logic             il,
  output logic [W-1:0]     reg_in,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state;
  logic [2:0]       op_q;
  logic [2:0]       oc_q;
  logic [W-1:0]     data_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             is_rep;
  logic             last;

  // INC/DEC/SHR/SHL occupy the upper half of the op space
  assign is_rep = op_q[2];
  assign last   = !is_rep || (cnt_q == '0);

  assign cmd_ready = rst_n && (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      op_q   <= OP_NOP;
      oc_q   <= '0;
      data_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (1'b1)
        (state == S_IDLE): begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            oc_q   <= cmd_oc;
            data_q <= cmd_data;
            cnt_q  <= cmd_cnt;
            state  <= (cmd_op == OP_ALU) ? S_SETUP : S_EXEC;
          end
        end
        (state == S_SETUP): begin
          state <= S_EXEC;
        end
        (state == S_EXEC): begin
          if (last) begin
            state  <= S_IDLE;
            cnt_q  <= '0;
            done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    alu_oc = '0;
    alu_b  = '0;
    reg_in = '0;
    cl     = 1'b0;
    ld     = 1'b0;
    inc    = 1'b0;
    dec    = 1'b0;
    sr     = 1'b0;
    sl     = 1'b0;
    ir     = 1'b0;
    il     = 1'b0;
    unique case (1'b1)
      (state == S_SETUP): begin
        alu_oc = oc_q;
        alu_b  = data_q;
      end
      (state == S_EXEC): begin
        unique case (op_q)
          OP_NOP: ;
          OP_CLR: cl = 1'b1;
          OP_LOAD: begin
            ld     = 1'b1;
            reg_in = data_q;
          end
          OP_ALU: begin
            ld     = 1'b1;
            reg_in = alu_f;
            alu_oc = oc_q;
            alu_b  = data_q;
          end
          OP_INC: inc = 1'b1;
          OP_DEC: dec = 1'b1;
          OP_SHR: begin
            sr = 1'b1;
            ir = data_q[SC_ROT] ? reg_out[0]
                                : data_q[SC_SER];
          end
          OP_SHL: begin
            sl = 1'b1;
            il = data_q[SC_ROT] ? reg_out[W-1]
                                : data_q[SC_SER];
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule
